rcv_frame_ctrl: RTL and testbench

UART receive frame controller sitting directly downstream of the start-bit detector in the UART debugger receive path. It consumes the detector's `start_detected` pulse together with the synchronized serial line. It times each bit period, samples data bits at mid-bit and checks the stop bit. It then presents the received byte to the debugger command logic through a ready/read handshake, with framing and overrun status.

---
 rtl/rcv_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rcv_frame_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rcv_frame_ctrl.sv
// UART receive frame controller: times bit periods after a detected start edge,
// samples data/stop mid-bit and hands the byte over with framing/overrun status.
// Optional even-parity bit and parity_error port are enabled by RCV_PARITY_EN.
module rcv_frame_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 serial_in,
  input  logic                 start_detected,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
`ifdef RCV_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  // state     | meaning
  // IDLE      | waiting for start_detected
  // START_CHK | half-bit wait, confirm start bit is still low
  // DATA      | sample DATA_BITS data bits, LSB first
  // PARITY    | sample even-parity bit (RCV_PARITY_EN only)
  // STOP      | sample stop bit
  // LOAD      | commit byte and status, back to IDLE
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_CHK = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] LOAD      = 3'd5;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_ok;
  logic                 half_tick;
  logic                 full_tick;
`ifdef RCV_PARITY_EN
  logic                 par_bit;
`endif

  assign half_tick = (bit_cnt == HALF_M1);
  assign full_tick = (bit_cnt == FULL_M1);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      stop_ok       <= 1'b0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
`ifdef RCV_PARITY_EN
      par_bit       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      // A read acknowledge clears status; a concurrent LOAD below overrides it.
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (start_detected) state <= START_CHK;
        end

        START_CHK: begin
          if (half_tick) begin
            bit_cnt <= '0;
            if (serial_in) begin
              state <= IDLE;
            end else begin
              state         <= DATA;
              framing_error <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        DATA: begin
          if (full_tick) begin
            bit_cnt <= '0;
            shreg   <= {serial_in, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef RCV_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

`ifdef RCV_PARITY_EN
        PARITY: begin
          if (full_tick) begin
            bit_cnt <= '0;
            par_bit <= serial_in;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
`endif

        STOP: begin
          if (full_tick) begin
            bit_cnt <= '0;
            stop_ok <= serial_in;
            state   <= LOAD;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        LOAD: begin
          state <= IDLE;
          if (stop_ok) begin
            rx_data    <= shreg;
            data_ready <= 1'b1;
            if (data_ready && !data_read) overrun_error <= 1'b1;
          end else begin
            framing_error <= 1'b1;
          end
`ifdef RCV_PARITY_EN
          parity_error <= ^{shreg, par_bit};
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rcv_frame_ctrl.sv
// Scoreboard bench for rcv_frame_ctrl: a frame-level model predicts the status
// after each frame, and a monitor compares it when busy drops.
module tb_rcv_frame_ctrl;
  localparam int CPB  = 10;
  localparam int DB   = 8;
  localparam int HALF = CPB / 2;
`ifdef RCV_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LOAD_C  = HALF + (DB + 1 + P) * CPB + 1;
  localparam int FRAME_C = (DB + 2 + P) * CPB;

  logic          clk = 1'b0;
  logic          Rst;
  logic          serial_in;
  logic          start_detected;
  logic          data_read;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic          framing_error;
  logic          overrun_error;
  logic          busy;
`ifdef RCV_PARITY_EN
  logic          parity_error;
`endif

  rcv_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk            (clk),
    .Rst            (Rst),
    .serial_in      (serial_in),
    .start_detected (start_detected),
    .data_read      (data_read),
    .rx_data        (rx_data),
    .data_ready     (data_ready),
    .framing_error  (framing_error),
    .overrun_error  (overrun_error),
`ifdef RCV_PARITY_EN
    .parity_error   (parity_error),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       rdy;
    logic       fe;
    logic       ov;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  logic [7:0] m_data;
  logic       m_rdy, m_fe, m_ov, m_pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: each busy fall marks the end of a frame attempt.
  logic prev_busy = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (Rst) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          check("unexpected_frame_end", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rx_data", 32'(rx_data), 32'(mon_e.d));
          check("data_ready", 32'(data_ready), 32'(mon_e.rdy));
          check("framing_error", 32'(framing_error), 32'(mon_e.fe));
          check("overrun_error", 32'(overrun_error), 32'(mon_e.ov));
`ifdef RCV_PARITY_EN
          check("parity_error", 32'(parity_error), 32'(mon_e.pe));
`endif
        end
      end
      prev_busy = busy;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      serial_in = 1'b1; start_detected = 1'b0; data_read = 1'b0;
    end
  endtask

  task automatic do_read();
    @(posedge clk); #1;
    serial_in = 1'b1; start_detected = 1'b0; data_read = 1'b1;
    m_rdy = 1'b0; m_ov = 1'b0;
    @(posedge clk); #1;
    data_read = 1'b0;
    @(negedge clk);
    check("read_clears_ready", 32'(data_ready), 32'(m_rdy));
    check("read_clears_overrun", 32'(overrun_error), 32'(m_ov));
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit,
                            input bit glitch, input bit rd_load, input int abort_at);
    logic [15:0] w;
    exp_t e;
    bit rd;
    rd = rd_load && !glitch;
    w = '1;
    w[0] = 1'b0;
    for (int k = 0; k < DB; k++) w[1+k] = d[k];
`ifdef RCV_PARITY_EN
    w[DB+1] = pbit;
`endif
    w[DB+1+P] = stop;

    if (abort_at < 0) begin
      if (!glitch) begin
        m_fe = 1'b0;
        if (stop) begin
          if (m_rdy && !rd) m_ov = 1'b1;
          else if (rd) m_ov = 1'b0;
          m_data = d;
          m_rdy  = 1'b1;
        end else begin
          m_fe = 1'b1;
          if (rd) begin m_rdy = 1'b0; m_ov = 1'b0; end
        end
        m_pe = ^{d, pbit};
      end
      e.d = m_data; e.rdy = m_rdy; e.fe = m_fe; e.ov = m_ov; e.pe = m_pe;
      sb.push_back(e);
    end

    for (int c = 0; c < FRAME_C; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) begin
        Rst = 1'b1; start_detected = 1'b0; serial_in = 1'b1; data_read = 1'b0;
        @(negedge clk);
        check("abort_rx_data", 32'(rx_data), 32'd0);
        check("abort_ready", 32'(data_ready), 32'd0);
        check("abort_fe", 32'(framing_error), 32'd0);
        check("abort_ov", 32'(overrun_error), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        m_data = '0; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
        @(posedge clk); #1;
        Rst = 1'b0;
        return;
      end
      start_detected = (c == 0);
      serial_in = glitch ? (c >= 3) : w[c / CPB];
      data_read = rd && (c == LOAD_C);
      @(negedge clk);
      if (c == 1) check("busy_rise", 32'(busy), 32'd1);
      if (glitch && c == HALF + 1) check("glitch_idle", 32'(busy), 32'd0);
      if (!glitch && c == HALF + 1) check("fe_clear_at_start", 32'(framing_error), 32'd0);
      if (!glitch && abort_at < 0 && c == LOAD_C) check("busy_in_load", 32'(busy), 32'd1);
      if (!glitch && abort_at < 0 && c == LOAD_C + 1) check("busy_fall", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; serial_in = 1'b1; start_detected = 1'b0; data_read = 1'b0;
    m_data = '0; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_ready", 32'(data_ready), 32'd0);
    check("reset_fe", 32'(framing_error), 32'd0);
    check("reset_ov", 32'(overrun_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    Rst = 1'b0;
    idle(3);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    do_read();
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    idle(2);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(1);
    do_read();
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(1);
    do_read();
    send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 40);
    idle(2);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(1);
    do_read();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(1);

    for (int i = 0; i < 25; i++) begin
      send_frame(8'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), -1);
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) do_read();
    end

    for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
